// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: reset PC default and next-PC select codes.
package pc_pkg;

    localparam int unsigned PC_RESET_DEFAULT = 0;

    typedef enum logic [2:0] {
        NXT_INC,
        NXT_RED,
        NXT_CALL,
        NXT_RET,
        NXT_HOLD
    } nxt_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] sp_q, sp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] top_idx;

    assign top_idx = sp_q - AW'(1);
    assign top     = mem_q[top_idx];
    assign count   = cnt_q;
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    // When full, sp already points at the oldest entry, so a push simply overwrites it.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d  = sp_q - AW'(1);
                cnt_d = cnt_q - (AW+1)'(1);
            end
        end else if (push) begin
            sp_d = sp_q + AW'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem_q[sp_q] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with redirect/stall/call/ret control.
// The return-address stack is built only when PC_RAS_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned STEP      = 1,
    parameter int unsigned RESET_PC  = PC_RESET_DEFAULT,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc,
    output logic            pc_valid,
    output logic            ras_ovf,
    output logic            ras_unf
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] inc_pc;
    logic [1:0]      vld_q;
    nxt_sel_e        sel;

    assign inc_pc = pc_q + PC_W'(STEP);

`ifdef PC_RAS_EN
    logic                        ras_push;
    logic                        ras_pop;
    logic [PC_W-1:0]             ras_top;
    logic [$clog2(RAS_DEPTH):0]  ras_count;
    logic                        ras_full;
    logic                        ras_empty;

    // Stack side effects only happen when neither redirect nor stall masks the op.
    assign ras_pop  = !redirect && !stall && ret;
    assign ras_push = !redirect && !stall && call && !ret;

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (inc_pc),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );
`else
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

    always_comb begin
        sel = NXT_INC;
        if (redirect) begin
            sel = NXT_RED;
        end else if (stall) begin
            sel = NXT_HOLD;
        end else if (ret) begin
`ifdef PC_RAS_EN
            sel = ras_empty ? NXT_INC : NXT_RET;
`else
            sel = NXT_INC;
`endif
        end else if (call) begin
`ifdef PC_RAS_EN
            sel = NXT_CALL;
`else
            sel = NXT_RED;
`endif
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            NXT_INC:  pc_d = inc_pc;
            NXT_RED:  pc_d = target;
            NXT_CALL: pc_d = target;
`ifdef PC_RAS_EN
            NXT_RET:  pc_d = ras_top;
`endif
            NXT_HOLD: pc_d = pc_q;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PC_W'(RESET_PC);
            vld_q <= '0;
        end else begin
            pc_q  <= pc_d;
            vld_q <= {vld_q[0], 1'b1};
        end
    end

    assign pc       = pc_q;
    assign next_pc  = pc_d;
    assign pc_valid = vld_q[1];

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter STEP, default 1, sequential increment added per advance.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 SHALL have port clk  in  1  single clock, rising-edge active.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port stall  in  1  hold PC and stack.
REQ-008 SHALL have port redirect  in  1  load target (branch/jump/flush).
REQ-009 SHALL have port call  in  1  push return address, load target.
REQ-010 SHALL have port ret  in  1  pop return address into PC.
REQ-011 SHALL have port target  in  PC_W  redirect/call destination.
REQ-012 SHALL have port pc  out  PC_W  registered current PC.
REQ-013 SHALL have port next_pc  out  PC_W  combinational value pc takes at next edge.
REQ-014 SHALL have port pc_valid  out  1  low during reset and the first cycle after release.
REQ-015 SHALL have port ras_ovf  out  1  one-cycle pulse: push while full.
REQ-016 SHALL have port ras_unf  out  1  one-cycle pulse: pop while empty.

Function
REQ-017 SHALL update pc <= next_pc on every rising clk edge; one-cycle latency from control to pc.
REQ-018 SHALL evaluate priority: redirect > stall > ret > call > increment.
REQ-019 SHALL on redirect load target, leave stack unchanged, regardless of stall.
REQ-020 SHALL on stall (no redirect) hold pc and stack; call/ret ignored, no flag pulses.
REQ-021 SHALL on increment compute pc+STEP modulo 2^PC_W (all-ones + 1 wraps to 0, no flag).
REQ-022 SHALL on call push (pc+STEP) mod 2^PC_W, load target.
REQ-023 SHALL on call while full overwrite the oldest entry (circular) and pulse ras_ovf; count stays RAS_DEPTH.
REQ-024 SHALL on ret load top entry and pop.
REQ-025 SHALL on ret while empty perform increment instead and pulse ras_unf.
REQ-026 SHALL on simultaneous call and ret perform ret only; call dropped.
REQ-027 SHALL set pc_valid one edge after the first unreset edge and keep it high until reset.

Reset
REQ-028 SHALL on reset assertion immediately force pc=RESET_PC, stack count=0, pc_valid=0, ras_ovf=0, ras_unf=0, independent of clk.
REQ-029 SHALL on reset mid-call/ret discard the operation; stack contents undefined, count 0.

Configuration
REQ-030 SHALL compile the return-address stack only when PC_RAS_EN is defined.
REQ-031 SHALL without PC_RAS_EN treat call as redirect, treat ret as increment, drive ras_ovf=ras_unf=0, keep all ports present.

Structure
REQ-032 SHALL place RESET_PC default, priority encoding typedef (NXT_INC, NXT_RED, NXT_CALL, NXT_RET, NXT_HOLD) in shared package pc_pkg.
REQ-033 SHALL implement the stack as sub-module pc_ras (push, pop, top, count, full, empty, ovf, unf).

Verification
REQ-034 SHALL cover reset release, PC_W=16, STEP=1 -> pc=0, 1, 2; pc_valid low the first cycle, high thereafter.
REQ-035 SHALL cover pc=16'hFFFF, increment -> pc=16'h0000, no flag.
REQ-036 SHALL cover call target=16'h0100 at pc=16'h0020, then ret -> pc 16'h0100, then 16'h0021.
REQ-037 SHALL cover five calls with RAS_DEPTH=4 -> ras_ovf pulses once on fifth; four rets return the last four addresses; fifth ret pulses ras_unf, pc increments.
REQ-038 SHALL cover stall+call -> pc and stack unchanged; stall+redirect target=16'h0040 -> pc=16'h0040.
REQ-039 SHALL cover reset asserted between clk edges during call -> pc=RESET_PC immediately; subsequent ret pulses ras_unf.
